// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: FSM encoding and default widths.
package fetch_queue_pkg;

  localparam int DEFAULT_BITS_DATA = 32;
  localparam int DEFAULT_BITS_ADDR = 16;
  localparam int DEFAULT_DEPTH     = 4;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_REQ  = 2'd1,
    FQ_DROP = 2'd2
  } fqState_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular buffer of {pc, word} entries with flush; head is read combinationally.
module fq_fifo
  import fetch_queue_pkg::*;
#(
  parameter int BITS_DATA = DEFAULT_BITS_DATA,
  parameter int BITS_ADDR = DEFAULT_BITS_ADDR,
  parameter int DEPTH     = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [BITS_ADDR-1:0]   pushPc,
  input  logic [BITS_DATA-1:0]   pushData,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic [BITS_ADDR-1:0]   headPc,
  output logic [BITS_DATA-1:0]   headData
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [PW-1:0]        rdPtr;
  logic [PW-1:0]        wrPtr;
  logic [BITS_ADDR-1:0] pcMem   [DEPTH];
  logic [BITS_DATA-1:0] dataMem [DEPTH];
  logic                 doPush;
  logic                 doPop;

  assign doPush = push && (count != FULL);
  assign doPop  = pop && (count != '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is reset so the head outputs read as zero out of reset; flush leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pcMem[i]   <= '0;
        dataMem[i] <= '0;
      end
    end else if (doPush && !flush) begin
      pcMem[wrPtr]   <= pushPc;
      dataMem[wrPtr] <= pushData;
    end
  end

  assign headPc   = pcMem[rdPtr];
  assign headData = dataMem[rdPtr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: requests sequential words from memory and buffers them for decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int BITS_DATA = DEFAULT_BITS_DATA,
  parameter int BITS_ADDR = DEFAULT_BITS_ADDR,
  parameter int DEPTH     = DEFAULT_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mem_req,
  output logic [BITS_ADDR-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [BITS_DATA-1:0] mem_rdata,
  output logic                 ir_valid,
  output logic [BITS_DATA-1:0] ir_data,
  output logic [BITS_ADDR-1:0] ir_pc,
  input  logic                 ir_ready,
  input  logic                 redirect,
  input  logic [BITS_ADDR-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fqState_t             state;
  logic [BITS_ADDR-1:0] fetchPc;
  logic [CW-1:0]        count;
  logic [CW-1:0]        countAfterPop;
  logic                 push;
  logic                 pop;

  assign ir_valid      = (count != '0);
  assign pop           = ir_valid && ir_ready && !redirect;
  assign push          = (state == FQ_REQ) && mem_ack && !redirect;
  assign countAfterPop = count - CW'(pop);

  fq_fifo #(
    .BITS_DATA(BITS_DATA),
    .BITS_ADDR(BITS_ADDR),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pushPc  (fetchPc),
    .pushData(mem_rdata),
    .pop     (pop),
    .flush   (redirect),
    .count   (count),
    .headPc  (ir_pc),
    .headData(ir_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FQ_IDLE;
      fetchPc  <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      if (redirect)  fetchPc <= redirect_pc;
      else if (push) fetchPc <= fetchPc + 1'b1;

      unique case (state)
        FQ_IDLE: begin
          // A pop this cycle already frees a slot, so a full queue refills one cycle after ir_ready.
          if (!redirect && (countAfterPop < FULL)) begin
            state    <= FQ_REQ;
            mem_req  <= 1'b1;
            mem_addr <= fetchPc;
          end
        end
        FQ_REQ: begin
          if (mem_ack) begin
            if (!redirect && ((countAfterPop + 1'b1) < FULL)) begin
              mem_addr <= fetchPc + 1'b1;
            end else begin
              state   <= FQ_IDLE;
              mem_req <= 1'b0;
            end
          end else if (redirect) begin
            // The memory still owes us this word; keep the request up and discard it on ack.
            state <= FQ_DROP;
          end
        end
        FQ_DROP: begin
          if (mem_ack) begin
            state   <= FQ_IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= FQ_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed scenarios for fetch_queue against a memory whose word at address a is {~a, a}.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ir_valid;
  logic [31:0] ir_data;
  logic [15:0] ir_pc;
  logic        ir_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  logic autoAck;
  logic manualAck;
  int   checks;
  int   errors;

  function automatic logic [31:0] memWord(input logic [15:0] a);
    return {~a, a};
  endfunction

  assign mem_ack   = autoAck ? mem_req : manualAck;
  assign mem_rdata = memWord(mem_addr);

  fetch_queue dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .ir_valid   (ir_valid),
    .ir_data    (ir_data),
    .ir_pc      (ir_pc),
    .ir_ready   (ir_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic restart(input logic useAuto, input logic ready);
    reset = 1'b0; redirect = 1'b0; manualAck = 1'b0;
    autoAck = useAuto; ir_ready = ready;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; autoAck = 1'b0; manualAck = 1'b0;
    ir_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (3) tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0h exp 0", mem_req); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr got %0h exp 0", mem_addr); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got %0h exp 0", ir_valid); end
    checks++; if (ir_data !== 32'h0) begin errors++; $display("FAIL reset_ir_data got %0h exp 0", ir_data); end
    checks++; if (ir_pc !== 16'h0) begin errors++; $display("FAIL reset_ir_pc got %0h exp 0", ir_pc); end
  endtask

  task automatic test_stream();
    autoAck = 1'b1; ir_ready = 1'b1; reset = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL stream_first_req got %0h exp 1", mem_req); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL stream_first_addr got %0h exp 0", mem_addr); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL stream_latency got %0h exp 0", ir_valid); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0h exp 1", i, ir_valid); end
      checks++; if (ir_pc !== 16'(i)) begin errors++; $display("FAIL stream_pc[%0d] got %0h exp %0h", i, ir_pc, 16'(i)); end
      checks++; if (ir_data !== memWord(16'(i))) begin errors++; $display("FAIL stream_data[%0d] got %0h exp %0h", i, ir_data, memWord(16'(i))); end
    end
  endtask

  task automatic test_full();
    int reqCycles;
    restart(1'b1, 1'b0);
    reqCycles = 0;
    repeat (8) begin
      tick();
      if (mem_req) reqCycles++;
    end
    checks++; if (reqCycles !== 4) begin errors++; $display("FAIL full_push_count got %0d exp 4", reqCycles); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_no_req got %0h exp 0", mem_req); end
    checks++; if (ir_pc !== 16'h0) begin errors++; $display("FAIL full_head got %0h exp 0", ir_pc); end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL full_refill_req got %0h exp 1", mem_req); end
    checks++; if (mem_addr !== 16'h4) begin errors++; $display("FAIL full_refill_addr got %0h exp 4", mem_addr); end
    checks++; if (ir_pc !== 16'h1) begin errors++; $display("FAIL full_pop_head got %0h exp 1", ir_pc); end
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_single_req got %0h exp 0", mem_req); end
    ir_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      checks++; if (ir_pc !== 16'(i)) begin errors++; $display("FAIL full_order[%0d] got %0h exp %0h", i, ir_pc, 16'(i)); end
    end
  endtask

  task automatic test_drop();
    restart(1'b0, 1'b1);
    tick();
    checks++; if (mem_addr !== 16'h0 || mem_req !== 1'b1) begin errors++; $display("FAIL drop_start got req=%0h addr=%0h exp req=1 addr=0", mem_req, mem_addr); end
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL drop_req_held got %0h exp 1", mem_req); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL drop_addr_held1 got %0h exp 0", mem_addr); end
    tick();
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL drop_addr_held2 got %0h exp 0", mem_addr); end
    manualAck = 1'b1;
    tick();
    manualAck = 1'b0;
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL drop_discard got %0h exp 0", ir_valid); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL drop_idle_req got %0h exp 0", mem_req); end
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL drop_new_req got %0h exp 1", mem_req); end
    checks++; if (mem_addr !== 16'h0100) begin errors++; $display("FAIL drop_new_addr got %0h exp 100", mem_addr); end
    manualAck = 1'b1;
    tick();
    manualAck = 1'b0;
    checks++; if (ir_pc !== 16'h0100) begin errors++; $display("FAIL drop_first_pc got %0h exp 100", ir_pc); end
    checks++; if (ir_data !== memWord(16'h0100)) begin errors++; $display("FAIL drop_first_data got %0h exp %0h", ir_data, memWord(16'h0100)); end
  endtask

  task automatic test_redirect_ack();
    restart(1'b0, 1'b0);
    tick();
    manualAck = 1'b1;
    tick();
    checks++; if (ir_valid !== 1'b1 || ir_pc !== 16'h0) begin errors++; $display("FAIL rack_setup got valid=%0h pc=%0h exp valid=1 pc=0", ir_valid, ir_pc); end
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0; manualAck = 1'b0;
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rack_flush got %0h exp 0", ir_valid); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rack_idle got %0h exp 0", mem_req); end
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rack_new_req got %0h exp 1", mem_req); end
    checks++; if (mem_addr !== 16'h0040) begin errors++; $display("FAIL rack_new_addr got %0h exp 40", mem_addr); end
  endtask

  task automatic test_wrap();
    logic [15:0] expPc [3];
    expPc[0] = 16'hFFFE; expPc[1] = 16'hFFFF; expPc[2] = 16'h0000;
    restart(1'b1, 1'b1);
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wrap_hold got %0h exp 0", mem_req); end
    tick();
    checks++; if (mem_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_addr got %0h exp fffe", mem_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ir_pc !== expPc[i]) begin errors++; $display("FAIL wrap_pc[%0d] got %0h exp %0h", i, ir_pc, expPc[i]); end
      checks++; if (ir_data !== memWord(expPc[i])) begin errors++; $display("FAIL wrap_data[%0d] got %0h exp %0h", i, ir_data, memWord(expPc[i])); end
    end
  endtask

  task automatic test_async_reset();
    restart(1'b0, 1'b0);
    tick();
    manualAck = 1'b1;
    repeat (2) tick();
    manualAck = 1'b0;
    checks++; if (mem_req !== 1'b1 || ir_pc !== 16'h0) begin errors++; $display("FAIL areset_setup got req=%0h pc=%0h exp req=1 pc=0", mem_req, ir_pc); end
    #2 reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL areset_req got %0h exp 0", mem_req); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %0h exp 0", ir_valid); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL areset_addr got %0h exp 0", mem_addr); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0) begin errors++; $display("FAIL areset_restart got req=%0h addr=%0h exp req=1 addr=0", mem_req, mem_addr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_full();
    test_drop();
    test_redirect_ack();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
